// File: rtl/seg_scan_driver_if.sv
// Pattern/control inputs and pin outputs of the 4-digit scan driver.
// The display controller side is the master; the scan driver is the slave.
interface seg_scan_driver_if;
   logic [7:0] seg0;
   logic [7:0] seg1;
   logic [7:0] seg2;
   logic [7:0] seg3;
   logic [3:0] blinkMask;
   logic [2:0] bright;
   logic [3:0] an;
   logic [7:0] cathode;
   logic [1:0] digitIdx;
   logic       frameTick;

   modport master (
      output seg0, seg1, seg2, seg3, blinkMask, bright,
      input  an, cathode, digitIdx, frameTick
   );

   modport slave (
      input  seg0, seg1, seg2, seg3, blinkMask, bright,
      output an, cathode, digitIdx, frameTick
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode display with blanking gap,
// brightness PWM, per-digit blink and once-per-frame snapshot of the patterns.
module seg_scan_driver #(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned DIGIT_HZ     = 1000,
   parameter int unsigned BLANK_CYCLES = 1000,
   parameter int unsigned BLINK_HZ     = 2,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic             Clk100M,
   input  logic             resetN,
   seg_scan_driver_if.slave bus
);

   localparam int unsigned DWELL = CLK_HZ / DIGIT_HZ;
   localparam int unsigned SHOW  = DWELL - BLANK_CYCLES;
   localparam int unsigned HALF  = CLK_HZ / (2 * BLINK_HZ);
   localparam int          CW    = $clog2(DWELL);
   localparam int          TW    = CW + 4;
   localparam int          BW    = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);
   localparam logic [TW-1:0] SHOW_W     = TW'(SHOW);
   localparam logic [BW-1:0] HALF_LAST  = BW'(HALF - 1);
   localparam logic [3:0]    AN_OFF     = ACTIVE_LOW ? 4'hF : 4'h0;
   localparam logic [7:0]    CATH_OFF   = ACTIVE_LOW ? 8'hFF : 8'h00;

   generate
      if (DWELL < BLANK_CYCLES + 8) begin : g_bad_dwell
         $fatal(1, "seg_scan_driver: DWELL must be at least BLANK_CYCLES + 8");
      end
      if (HALF == 0) begin : g_bad_blink
         $fatal(1, "seg_scan_driver: blink half-period must be at least one cycle");
      end
   endgenerate

   typedef enum logic {
      PH_BLANK,
      PH_SHOW
   } phase_e;

   // Scan state
   logic [CW-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [1:0]    digit_q, digit_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic          load_pending_q, load_pending_d;
   logic          frame_start_q, frame_start_d;

   // Per-frame snapshot
   logic [7:0]    shadow_q [4];
   logic [7:0]    shadow_d [4];
   logic [3:0]    mask_q, mask_d;
   logic [2:0]    bright_q, bright_d;

   // Registered pins
   logic [3:0]    an_q, an_d;
   logic [7:0]    cathode_q, cathode_d;
   logic [1:0]    digit_idx_q, digit_idx_d;
   logic          frame_tick_q, frame_tick_d;

   phase_e        phase;
   logic          slot_wrap;
   logic          frame_wrap;
   logic          load;
   logic [CW-1:0] show_pos;
   logic [TW-1:0] bright_plus1;
   logic [TW-1:0] thr;
   logic          lit;

   // NOTE: every signal assigned in an always_comb gets a default on entry,
   // so no path through the block leaves a value held and no latch is inferred.
   always_comb begin
      dwell_cnt_d    = dwell_cnt_q + 1'b1;
      digit_d        = digit_q;
      blink_cnt_d    = blink_cnt_q + 1'b1;
      blink_phase_d  = blink_phase_q;
      load_pending_d = 1'b0;
      shadow_d       = shadow_q;
      mask_d         = mask_q;
      bright_d       = bright_q;

      slot_wrap  = (dwell_cnt_q == DWELL_LAST);
      frame_wrap = slot_wrap && (digit_q == 2'd3);
      load       = load_pending_q || frame_wrap;

      if (slot_wrap) begin
         dwell_cnt_d = '0;
         digit_d     = digit_q + 2'd1;
      end

      // Blink runs on its own clock-derived period, unrelated to frame timing.
      if (blink_cnt_q == HALF_LAST) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end

      if (load) begin
         shadow_d[0] = bus.seg0;
         shadow_d[1] = bus.seg1;
         shadow_d[2] = bus.seg2;
         shadow_d[3] = bus.seg3;
         mask_d      = bus.blinkMask;
         bright_d    = bus.bright;
      end

      frame_start_d = frame_wrap;
   end

   always_comb begin
      phase        = (dwell_cnt_q < BLANK_END) ? PH_BLANK : PH_SHOW;
      show_pos     = dwell_cnt_q - BLANK_END;
      // Product is formed at full width; bright=7 yields exactly SHOW.
      bright_plus1 = TW'(bright_q) + TW'(1);
      thr          = (bright_plus1 * SHOW_W) >> 3;
      lit          = (phase == PH_SHOW) && (TW'(show_pos) < thr) &&
                     !(mask_q[digit_q] && !blink_phase_q);

      an_d      = AN_OFF;
      cathode_d = CATH_OFF;
      if (lit) begin
         an_d      = AN_OFF ^ (4'b0001 << digit_q);
         cathode_d = CATH_OFF ^ shadow_q[digit_q];
      end
      digit_idx_d  = digit_q;
      frame_tick_d = frame_start_q;
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of block order.
   always_ff @(posedge Clk100M or negedge resetN) begin
      if (!resetN) begin
         dwell_cnt_q    <= '0;
         digit_q        <= '0;
         blink_cnt_q    <= '0;
         blink_phase_q  <= 1'b1;
         load_pending_q <= 1'b1;
         frame_start_q  <= 1'b0;
         mask_q         <= '0;
         bright_q       <= '0;
         an_q           <= AN_OFF;
         cathode_q      <= CATH_OFF;
         digit_idx_q    <= '0;
         frame_tick_q   <= 1'b0;
      end else begin
         dwell_cnt_q    <= dwell_cnt_d;
         digit_q        <= digit_d;
         blink_cnt_q    <= blink_cnt_d;
         blink_phase_q  <= blink_phase_d;
         load_pending_q <= load_pending_d;
         frame_start_q  <= frame_start_d;
         mask_q         <= mask_d;
         bright_q       <= bright_d;
         an_q           <= an_d;
         cathode_q      <= cathode_d;
         digit_idx_q    <= digit_idx_d;
         frame_tick_q   <= frame_tick_d;
      end
   end

   // NOTE: the four shadow bytes are a tiny register file, not a RAM, so they
   // take the async reset like the rest of the state and come up blank.
   always_ff @(posedge Clk100M or negedge resetN) begin
      if (!resetN) begin
         for (int k = 0; k < 4; k++) shadow_q[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) shadow_q[k] <= shadow_d[k];
      end
   end

   assign bus.an        = an_q;
   assign bus.cathode   = cathode_q;
   assign bus.digitIdx  = digit_idx_q;
   assign bus.frameTick = frame_tick_q;

endmodule
